// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/WAIT/HOLD fetch FSM with redirect support.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects in align_fault.
module instr_fetch_unit #(
  parameter int             PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] pc_plus4,
  input  logic            instr_ack,
  output logic            align_fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] PC_RST = RESET_PC & ALIGN_MASK;
  localparam logic [PC_W-1:0] STEP = PC_W'(4);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            fault;

  assign imem_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic redir_bad;

  assign redir_bad = |redirect_pc[1:0];
  assign fault = fault_q;
  assign align_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && redir_bad) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
  assign align_fault = 1'b0;
`endif

  // WAIT spans two cycles: the strobe cycle (imem_en=1), then capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC_RST;
      imem_en     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pc_plus4    <= '0;
    end else if (redirect_valid) begin
      state       <= IDLE;
      imem_en     <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (!redir_bad) begin
        pc <= redirect_pc;
      end
`else
      pc <= redirect_pc & ALIGN_MASK;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_req && !fault) begin
            imem_en <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (imem_en) begin
            imem_en <= 1'b0;
          end else begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc_plus4    <= pc + STEP;
            pc          <= pc + STEP;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a scoreboard queue.
// Uses a synchronous memory model whose data depends on the address.
module tb_instr_fetch_unit;

  localparam int PC_W = 10;

  typedef struct packed {
    logic [31:0]     i;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] p4;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            fetch_req;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic [PC_W-1:0] pc_plus4;
  logic            instr_ack;
  logic            align_fault;

  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  exp_t sbq[$];

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .pc_plus4(pc_plus4),
    .instr_ack(instr_ack),
    .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [PC_W-1:0] a);
    if (a == '0) return 32'h2008_0005;
    return {12'hC0D, 10'd0, a};
  endfunction

  // Read data is valid only in the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_en) begin
      imem_rdata <= memw(imem_addr);
      en_cnt = en_cnt + 1;
    end else begin
      imem_rdata <= 32'hDEAD_BEEF;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    fetch_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic do_redirect(input logic [PC_W-1:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic fetch_one(input logic [PC_W-1:0] pc, input bit poke);
    exp_t e;
    exp_t got;
    int   k;
    int   c0;
    e.i = memw(pc);
    e.pc = pc;
    e.p4 = pc + PC_W'(4);
    sbq.push_back(e);
    c0 = en_cnt;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== pc) begin
      errors++;
      $display("FAIL strobe en=%b addr=%h exp en=1 addr=%h",
               imem_en, imem_addr, pc);
    end
    k = 1;
    while (instr_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL latency got %0d exp 3 (pc %h)", k, pc);
    end
    if (instr_valid === 1'b1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      got = {instr, instr_pc, pc_plus4};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL data got %h/%h/%h exp %h/%h/%h",
                 instr, instr_pc, pc_plus4, e.i, e.pc, e.p4);
      end
    end else begin
      sbq.delete();
    end
    if (poke) begin
      fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      checks++;
      if (imem_en !== 1'b0 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_ignore en=%b valid=%b exp en=0 valid=1",
                 imem_en, instr_valid);
      end
    end
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || en_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL ack valid=%b strobes=%0d exp valid=0 strobes=1",
               instr_valid, en_cnt - c0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({instr_valid, imem_en, align_fault} !== 3'b000 ||
        instr !== 32'h0 || instr_pc !== '0 ||
        pc_plus4 !== '0 || imem_addr !== '0) begin
      errors++;
      $display("FAIL reset v=%b en=%b f=%b i=%h pc=%h p4=%h a=%h exp zeros",
               instr_valid, imem_en, align_fault, instr, instr_pc,
               pc_plus4, imem_addr);
    end
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h040;
    fetch_req = 1'b1;
    instr_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    redirect_valid = 1'b0;
    fetch_req = 1'b0;
    instr_ack = 1'b0;
    checks++;
    if (imem_addr !== '0 || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_prio addr=%h en=%b exp addr=000 en=0",
               imem_addr, imem_en);
    end
  endtask

  task automatic test_basic();
    do_reset();
    fetch_one(10'h000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = en_cnt;
    for (int n = 0; n < 3; n++) begin
      fetch_one(PC_W'(n * 4), n == 1);
    end
    checks++;
    if (en_cnt - c0 !== 3) begin
      errors++;
      $display("FAIL b2b_strobes got %0d exp 3", en_cnt - c0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_redirect(10'h3FC);
    fetch_one(10'h3FC, 1'b0);
    fetch_one(10'h000, 1'b0);
  endtask

  task automatic test_redirect_wait();
    for (int d = 1; d <= 2; d++) begin
      do_reset();
      fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      repeat (d - 1) @(negedge clk);
      do_redirect(10'h040);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin
          errors++;
          $display("FAIL redir_wait d=%0d valid=%b en=%b exp 0/0",
                   d, instr_valid, imem_en);
        end
        @(negedge clk);
      end
      fetch_one(10'h040, 1'b0);
    end
  endtask

  task automatic test_redirect_hold();
    int k;
    do_reset();
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    k = 0;
    while (instr_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== memw(10'h000)) begin
      errors++;
      $display("FAIL hold_setup valid=%b instr=%h exp 1/%h",
               instr_valid, instr, memw(10'h000));
    end
    instr_ack = 1'b1;
    do_redirect(10'h100);
    instr_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 10'h100) begin
      errors++;
      $display("FAIL redir_hold valid=%b addr=%h exp 0/100",
               instr_valid, imem_addr);
    end
    fetch_one(10'h100, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_redirect(10'h080);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (instr_valid !== 1'b0 || imem_addr !== '0) begin
        errors++;
        $display("FAIL reset_mid valid=%b addr=%h exp 0/000",
                 instr_valid, imem_addr);
      end
      @(negedge clk);
    end
    fetch_one(10'h000, 1'b0);
  endtask

  task automatic test_align();
    do_reset();
    do_redirect(10'h010);
    do_redirect(10'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    begin
      int c0;
      checks++;
      if (align_fault !== 1'b1 || imem_addr !== 10'h010) begin
        errors++;
        $display("FAIL align_trap f=%b addr=%h exp 1/010",
                 align_fault, imem_addr);
      end
      c0 = en_cnt;
      fetch_req = 1'b1;
      repeat (3) @(negedge clk);
      fetch_req = 1'b0;
      @(negedge clk);
      checks++;
      if (en_cnt !== c0 || instr_valid !== 1'b0 || align_fault !== 1'b1) begin
        errors++;
        $display("FAIL align_block strobes=%0d v=%b f=%b exp 0/0/1",
                 en_cnt - c0, instr_valid, align_fault);
      end
      do_reset();
      checks++;
      if (align_fault !== 1'b0) begin
        errors++;
        $display("FAIL align_clear f=%b exp 0", align_fault);
      end
      fetch_one(10'h000, 1'b0);
    end
`else
    checks++;
    if (align_fault !== 1'b0 || imem_addr !== 10'h100) begin
      errors++;
      $display("FAIL align_force f=%b addr=%h exp 0/100",
               align_fault, imem_addr);
    end
    fetch_one(10'h100, 1'b0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_redirect_wait();
    test_redirect_hold();
    test_reset_mid();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
